// File: rtl/parity_frame_accum_pkg.sv
// Shared types and constants for the frame parity accumulator and related checkers.
package parity_pkg;

  typedef enum logic {
    EMPTY  = 1'b0,
    ACTIVE = 1'b1
  } acc_state_t;

  localparam bit PARITY_EVEN = 1'b0;
  localparam bit PARITY_ODD  = 1'b1;

endpackage

// File: rtl/parity_frame_accum_if.sv
// Beat stream in, per-frame parity result out. master drives beats and sinks results.
interface parity_frame_accum_if #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 8
);
  logic [WIDTH-1:0]   in_data;
  logic               in_valid;
  logic               in_last;
  logic               in_ready;
  logic               out_parity;
  logic [COUNT_W-1:0] out_count;
  logic               out_sat;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_parity, out_count, out_sat, out_valid
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_parity, out_count, out_sat, out_valid
  );
endinterface

// File: rtl/parity_frame_accum_xor_reduce_tree.sv
// Balanced pairwise XOR reduction; leaves padded with zeros up to a power of two.
module xor_reduce_tree #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] arg_0,
  output logic             out
);
  localparam int LVLS = $clog2(WIDTH);
  localparam int P    = 1 << LVLS;

  // Heap layout: node i combines children 2i and 2i+1, leaves at P..2P-1.
  logic [2*P-1:1] node;

  always_comb begin
    node = '0;
    for (int j = 0; j < WIDTH; j++) node[P+j] = arg_0[j];
    for (int i = P - 1; i >= 1; i--) node[i] = node[2*i] ^ node[2*i+1];
  end

  assign out = node[1];
endmodule

// File: rtl/parity_frame_accum.sv
// Streaming frame parity: XOR of all bits per frame, saturating beat count, one result per frame.
module parity_frame_accum
  import parity_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 8,
  parameter bit ODD     = PARITY_EVEN
) (
  input logic clock,
  input logic reset_n,
  parity_frame_accum_if.slave bus
);
  acc_state_t         state_q, state_d;
  logic               acc_q, acc_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic               sat_q, sat_d;
  logic               par_q, par_d;
  logic [COUNT_W-1:0] ocnt_q, ocnt_d;
  logic               osat_q, osat_d;
  logic               oval_q, oval_d;

  logic               beat_par;
  logic               in_ready;
  logic               accept;
  logic               at_max;
  logic [COUNT_W-1:0] cnt_inc;
  logic               sat_inc;

  xor_reduce_tree #(.WIDTH(WIDTH)) u_tree (
    .arg_0 (bus.in_data),
    .out   (beat_par)
  );

  assign in_ready = !oval_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  // Count including the current beat; sticks at all-ones and flags the overflow.
  assign at_max  = &cnt_q;
  assign cnt_inc = at_max ? cnt_q : cnt_q + COUNT_W'(1);
  assign sat_inc = sat_q | at_max;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    par_d   = par_q;
    ocnt_d  = ocnt_q;
    osat_d  = osat_q;
    oval_d  = oval_q;

    if (oval_q && bus.out_ready) oval_d = 1'b0;

    if (accept) begin
      if (bus.in_last) begin
        par_d   = acc_q ^ beat_par ^ ODD;
        ocnt_d  = cnt_inc;
        osat_d  = sat_inc;
        oval_d  = 1'b1;
        acc_d   = 1'b0;
        cnt_d   = '0;
        sat_d   = 1'b0;
        state_d = EMPTY;
      end else begin
        acc_d   = acc_q ^ beat_par;
        cnt_d   = cnt_inc;
        sat_d   = sat_inc;
        state_d = ACTIVE;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      acc_q   <= 1'b0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      par_q   <= 1'b0;
      ocnt_q  <= '0;
      osat_q  <= 1'b0;
      oval_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      par_q   <= par_d;
      ocnt_q  <= ocnt_d;
      osat_q  <= osat_d;
      oval_q  <= oval_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_parity = par_q;
  assign bus.out_count  = ocnt_q;
  assign bus.out_sat    = osat_q;
  assign bus.out_valid  = oval_q;
endmodule

// File: tb/tb_parity_frame_accum.sv
// Drives an even and an odd parity instance with the same stream and checks both against a frame model.
module tb_parity_frame_accum;
  localparam int W  = 8;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [W-1:0] in_data = '0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  parity_frame_accum_if #(.WIDTH(W), .COUNT_W(CW)) bus0 ();
  parity_frame_accum_if #(.WIDTH(W), .COUNT_W(CW)) bus1 ();

  assign bus0.in_data   = in_data;
  assign bus0.in_valid  = in_valid;
  assign bus0.in_last   = in_last;
  assign bus0.out_ready = out_ready;
  assign bus1.in_data   = in_data;
  assign bus1.in_valid  = in_valid;
  assign bus1.in_last   = in_last;
  assign bus1.out_ready = out_ready;

  parity_frame_accum #(.WIDTH(W), .COUNT_W(CW), .ODD(1'b0)) dut_even (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus0.slave)
  );

  parity_frame_accum #(.WIDTH(W), .COUNT_W(CW), .ODD(1'b1)) dut_odd (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus1.slave)
  );

  // Model: frame = total set bits and total beats; result follows from the rules.
  int m_ones = 0;
  int m_beats = 0;
  bit m_valid = 0;
  bit m_par_e = 0;
  bit m_par_o = 0;
  int m_cnt = 0;
  bit m_sat = 0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_ones  <= 0;
      m_beats <= 0;
      m_valid <= 0;
      m_par_e <= 0;
      m_par_o <= 0;
      m_cnt   <= 0;
      m_sat   <= 0;
    end else begin
      int ones;
      int n;
      if (m_valid && out_ready) m_valid <= 0;
      if (in_valid && (!m_valid || out_ready)) begin
        ones = m_ones + $countones(in_data);
        n    = m_beats + 1;
        if (in_last) begin
          m_par_e <= ones[0];
          m_par_o <= !ones[0];
          m_cnt   <= (n > CMAX) ? CMAX : n;
          m_sat   <= (n > CMAX);
          m_valid <= 1;
          m_ones  <= 0;
          m_beats <= 0;
        end else begin
          m_ones  <= ones;
          m_beats <= n;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      chk("cmp in_ready",    32'(bus0.in_ready),   32'(!m_valid || out_ready));
      chk("cmp out_valid",   32'(bus0.out_valid),  32'(m_valid));
      chk("cmp par_even",    32'(bus0.out_parity), 32'(m_par_e));
      chk("cmp out_count",   32'(bus0.out_count),  32'(m_cnt));
      chk("cmp out_sat",     32'(bus0.out_sat),    32'(m_sat));
      chk("cmp odd valid",   32'(bus1.out_valid),  32'(m_valid));
      chk("cmp par_odd",     32'(bus1.out_parity), 32'(m_par_o));
      chk("cmp odd count",   32'(bus1.out_count),  32'(m_cnt));
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic beat(input logic [W-1:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    step();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    repeat (2) step();
    chk("reset valid", 32'(bus0.out_valid), 0);
    chk("reset count", 32'(bus0.out_count), 0);
    reset_n = 1'b1;
    chk("post-reset in_ready", 32'(bus0.in_ready), 1);
    step();

    // Single-beat frame
    beat(8'h03, 1'b1);
    idle();
    chk("single valid",    32'(bus0.out_valid),  1);
    chk("single par even", 32'(bus0.out_parity), 0);
    chk("single count",    32'(bus0.out_count),  1);
    chk("single par odd",  32'(bus1.out_parity), 1);
    step();

    // Three-beat frame then back-to-back single
    beat(8'h01, 1'b0);
    beat(8'h02, 1'b0);
    beat(8'h04, 1'b1);
    chk("three par",   32'(bus0.out_parity), 1);
    chk("three count", 32'(bus0.out_count),  3);
    beat(8'hFF, 1'b1);
    idle();
    chk("b2b valid", 32'(bus0.out_valid),  1);
    chk("b2b par",   32'(bus0.out_parity), 0);
    chk("b2b count", 32'(bus0.out_count),  1);
    step();

    // Backpressure
    out_ready = 1'b0;
    beat(8'h10, 1'b1);
    in_data = 8'h80;
    for (int i = 0; i < 5; i++) begin
      chk("bp in_ready", 32'(bus0.in_ready),   0);
      chk("bp par hold", 32'(bus0.out_parity), 1);
      chk("bp cnt hold", 32'(bus0.out_count),  1);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp ready comb", 32'(bus0.in_ready), 1);
    step();
    idle();
    chk("bp new par",   32'(bus0.out_parity), 1);
    chk("bp new count", 32'(bus0.out_count),  1);
    chk("bp new valid", 32'(bus0.out_valid),  1);
    step();

    // Saturation
    for (int i = 0; i < 17; i++) beat(8'h00, i == 16);
    idle();
    chk("sat count", 32'(bus0.out_count),  15);
    chk("sat flag",  32'(bus0.out_sat),    1);
    chk("sat par",   32'(bus0.out_parity), 0);
    beat(8'h01, 1'b1);
    idle();
    chk("post-sat flag", 32'(bus0.out_sat), 0);

    // Asynchronous reset with a pending result
    out_ready = 1'b0;
    #3;
    reset_n = 1'b0;
    #1;
    chk("async valid", 32'(bus0.out_valid),  0);
    chk("async par",   32'(bus0.out_parity), 0);
    chk("async count", 32'(bus0.out_count),  0);
    chk("async sat",   32'(bus0.out_sat),    0);
    #2;
    reset_n = 1'b1;
    chk("release in_ready", 32'(bus0.in_ready), 1);
    out_ready = 1'b1;
    step();

    // Reset mid-frame discards the partial frame
    beat(8'h01, 1'b0);
    beat(8'h01, 1'b0);
    idle();
    #2;
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    step();
    beat(8'h01, 1'b1);
    idle();
    chk("midrst par",   32'(bus0.out_parity), 1);
    chk("midrst count", 32'(bus0.out_count),  1);
    chk("midrst sat",   32'(bus0.out_sat),    0);
    step();

    // Random traffic; long-frame segments reach saturation
    for (int seg = 0; seg < 8; seg++) begin
      int lmod;
      lmod = (seg % 2 == 0) ? 4 : 24;
      for (int c = 0; c < 300; c++) begin
        in_valid  = ($urandom_range(0, 9) < 7);
        in_data   = W'($urandom);
        in_last   = ($urandom_range(0, lmod - 1) == 0);
        out_ready = ($urandom_range(0, 9) < 6);
        step();
      end
    end
    idle();
    out_ready = 1'b1;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/parity_frame_accum.md
# parity_frame_accum

Streaming parity accumulator: computes the XOR reduction of every bit in a frame of `WIDTH`-bit words and reports one parity result per frame, together with a beat count. It generalises the two-input XOR cell to arbitrary word width, multi-beat frames, even/odd parity mode and valid/ready handshakes on both sides. It sits between a framed byte/word stream source and a checker or packet-trailer generator.

## Interface
- `WIDTH`, default 8: input word width, ≥1.
- `COUNT_W`, default 8: width of the beat counter, ≥1.
- `ODD`, default 0: 0 = even parity (result = XOR of all bits); 1 = odd parity (result inverted).

- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  WIDTH  input word.
- `in_valid`  in  1  input beat valid.
- `in_last`  in  1  beat is the final beat of its frame; qualified by `in_valid`.
- `in_ready`  out  1  block accepts a beat this cycle.
- `out_parity`  out  1  frame parity result.
- `out_count`  out  COUNT_W  beats in the frame, saturating.
- `out_sat`  out  1  the beat count saturated in this frame.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.

## Operation
- Beat accepted when `in_valid && in_ready`.
- `in_ready = !out_valid || out_ready`: combinational, with no dependency on `in_valid` or `in_data`.
- Accumulator state: `acc` (1 bit), `cnt` (COUNT_W), `sat` (1), FSM `EMPTY` or `ACTIVE`.
- On each accepted beat, compute the beat parity `p = ^in_data`.
- Accepted non-last beat:
  - `acc <= acc ^ p`.
  - `cnt <= cnt + 1`, saturating at 2^COUNT_W−1; `sat` is set when an increment would exceed the maximum.
  - FSM moves to `ACTIVE`.
- Accepted last beat:
  - Output registers load `out_parity <= acc ^ p ^ ODD`, `out_count <= sat-adjusted cnt + 1` (same saturation rule), `out_sat` likewise, and `out_valid <= 1`.
  - Accumulator clears (`acc=0`, `cnt=0`, `sat=0`); FSM returns to `EMPTY`.
- Single-beat frame (last beat in `EMPTY`) gives `out_count = 1`.
- Result handshake:
  - `out_valid && out_ready` with no new last beat in the same cycle: `out_valid <= 0`.
  - Simultaneous drain and new last beat: the output reloads with the new result and `out_valid` stays 1. This gives back-to-back frames one result per cycle.
- While `out_valid && !out_ready`:
  - `in_ready = 0`; no beats are accepted.
  - Output fields are held stable.
- `in_last` with `in_valid = 0` is ignored.
- Reset (asynchronous assert, any state, including mid-frame):
  - `acc=0`, `cnt=0`, `sat=0`, FSM=`EMPTY`.
  - `out_valid=0`, `out_parity=0`, `out_count=0`, `out_sat=0`.
  - Any partial frame is discarded.
- Reset release is synchronous to `clock`, handled by the system reset synchroniser; the block needs no internal handling.

## Timing
- Latency: last beat accepted at edge N → `out_valid` = 1 after edge N.
- Throughput: 1 beat/cycle when `out_ready = 1`.
- `in_ready` goes high combinationally in the same cycle `out_ready` rises.
- Critical path: WIDTH-input XOR tree plus 2 XORs into the output register. No pipelining for `WIDTH ≤ 64`.
- Reset values: `in_ready=1` (out of reset), `out_valid=0`, `out_parity=0`, `out_count=0`, `out_sat=0`.

## Structure
- Shared package `parity_pkg`:
  - FSM enum `acc_state_t {EMPTY, ACTIVE}`.
  - Parity-mode constants `PARITY_EVEN=0`, `PARITY_ODD=1`.
- Sub-module `xor_reduce_tree`: purely combinational, parameter `WIDTH`, input `arg_0[WIDTH]`, output `out[1]`. It is a balanced pairwise XOR tree and is reused by other checkers.
- Top level holds the FSM, accumulator, saturating counter and output register.

## Test plan
All scenarios use `WIDTH=8`, `COUNT_W=4`, `ODD=0` unless stated.

- **Reset:** assert `reset_n=0` mid-cycle → immediately `out_valid=0`, `out_parity=0`, `out_count=0`, `out_sat=0`; after release `in_ready=1`.
- **Single-beat frame:** `in_data=8'h03`, `in_last=1` → next cycle `out_parity=0`, `out_count=1`, `out_valid=1`. Repeat with `ODD=1` → `out_parity=1`.
- **Three-beat frame:** `8'h01`, `8'h02`, `8'h04`(last), `out_ready=1` → one result, `out_parity=1`, `out_count=3`. Then a back-to-back frame `8'hFF`(last) → `out_parity=0`, `out_count=1` on the following cycle with no bubble.
- **Backpressure:** result pending with `out_ready=0` for 5 cycles → `in_ready=0` and outputs stable. Raise `out_ready` with a last beat `8'h80` presented → accepted the same cycle; next cycle `out_parity=1`, `out_count=1`.
- **Saturation:** 17 beats of `8'h00`, last on the 17th → `out_count=15`, `out_sat=1`, `out_parity=0`. The next frame reports `out_sat=0`.
- **Reset mid-frame:** 2 beats of `8'h01`, pulse `reset_n` low, then `8'h01`(last) → `out_parity=1`, `out_count=1`.
